// File: rtl/sound_frame_seq.sv
// -----------------------------------------------------------------------------
// sound_frame_seq
//
// APU frame sequencer and trigger scheduler.
//
// The 512 Hz frame-step timebase comes from falling edges of one bit of the
// free-running system divider. Each frame step issues registered, single-cycle
// strobes to the length counters, the channel 1 sweep unit and the volume
// envelopes. Per-channel trigger writes are re-timed into one-cycle start
// pulses.
//
// Ports:
//   clk        system clock (single domain)
//   rst        synchronous active-high reset
//   apu_en     master sound enable; while low, step/strobes/start are held at 0
//   div        free-running system divider (may jump to 0 on a DIV write)
//   trig_wr    per-channel trigger write pulse (bit i = channel i+1)
//   step       index of the next frame step to execute
//   clk_length length-counter tick (steps 0,2,4,6)
//   clk_sweep  sweep tick (steps 2,6)
//   clk_env    envelope tick (step 7)
//   start      per-channel one-cycle start pulses
//   len_skip   next step does not clock length (step[0])
// -----------------------------------------------------------------------------
module sound_frame_seq #(
  parameter int DIV_WIDTH = 16,
  parameter int DIV_BIT   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 apu_en,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [3:0]           trig_wr,
  output logic [2:0]           step,
  output logic                 clk_length,
  output logic                 clk_sweep,
  output logic                 clk_env,
  output logic [3:0]           start,
  output logic                 len_skip
);

  logic       div_q_r;
  logic       tick_s;
  logic [2:0] step_nxt_s;
  logic       length_nxt_s;
  logic       sweep_nxt_s;
  logic       env_nxt_s;
  logic [3:0] start_nxt_s;
  logic       div_unused_s;

  // Only one divider bit is observed; the rest of the bus is intentionally
  // left unused.
  assign div_unused_s = ^div;

  // A falling edge of the selected divider bit, including the one caused by
  // a DIV write clearing a set bit.
  assign tick_s = div_q_r & ~div[DIV_BIT];

  // Channels read this straight off the step register so it lines up with
  // step in the same cycle.
  assign len_skip = step[0];

  // Next-state decode: step advance, strobe selection and trigger gating.
  always_comb begin
    step_nxt_s   = step;
    length_nxt_s = 1'b0;
    sweep_nxt_s  = 1'b0;
    env_nxt_s    = 1'b0;
    start_nxt_s  = 4'b0000;
    if (!apu_en) begin
      // Disabled: sequencer parked at step 0, ticks and triggers dropped.
      step_nxt_s   = 3'd0;
      length_nxt_s = 1'b0;
      sweep_nxt_s  = 1'b0;
      env_nxt_s    = 1'b0;
      start_nxt_s  = 4'b0000;
    end else begin
      start_nxt_s = trig_wr;
      if (tick_s) begin
        step_nxt_s   = step + 3'd1;
        length_nxt_s = ~step[0];
        sweep_nxt_s  = (step[1:0] == 2'b10);
        env_nxt_s    = (step == 3'd7);
      end else begin
        step_nxt_s   = step;
        length_nxt_s = 1'b0;
        sweep_nxt_s  = 1'b0;
        env_nxt_s    = 1'b0;
      end
    end
  end

  // State and output registers; the divider bit is sampled even when disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q_r    <= 1'b0;
      step       <= 3'd0;
      clk_length <= 1'b0;
      clk_sweep  <= 1'b0;
      clk_env    <= 1'b0;
      start      <= 4'b0000;
    end else begin
      div_q_r    <= div[DIV_BIT];
      step       <= step_nxt_s;
      clk_length <= length_nxt_s;
      clk_sweep  <= sweep_nxt_s;
      clk_env    <= env_nxt_s;
      start      <= start_nxt_s;
    end
  end

endmodule

// File: tb/tb_sound_frame_seq.sv
// -----------------------------------------------------------------------------
// tb_sound_frame_seq
//
// Self-checking bench for sound_frame_seq. A behavioural model counts executed
// frame steps since enable and derives the strobes arithmetically from that
// count; every cycle the DUT outputs are compared against it. Directed
// scenarios add literal expectations, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_sound_frame_seq;

  localparam int DW = 16;
  localparam int DB = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          apu_en;
  logic [DW-1:0] div;
  logic [3:0]    trig_wr;
  logic [2:0]    step;
  logic          clk_length;
  logic          clk_sweep;
  logic          clk_env;
  logic [3:0]    start;
  logic          len_skip;

  int checks = 0;
  int errors = 0;

  // DUT strobe tallies, maintained by the checking process only
  int n_len = 0;
  int n_sw  = 0;
  int n_env = 0;

  always #5 clk = ~clk;

  sound_frame_seq #(.DIV_WIDTH(DW), .DIV_BIT(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .apu_en     (apu_en),
    .div        (div),
    .trig_wr    (trig_wr),
    .step       (step),
    .clk_length (clk_length),
    .clk_sweep  (clk_sweep),
    .clk_env    (clk_env),
    .start      (start),
    .len_skip   (len_skip)
  );

  // ---------------- behavioural model ----------------
  // m_n = number of frame steps executed since reset / last enable.
  logic       m_prev = 1'b0;
  int         m_n    = 0;
  logic       e_len  = 1'b0;
  logic       e_sw   = 1'b0;
  logic       e_env  = 1'b0;
  logic [3:0] e_start = 4'b0000;

  always @(posedge clk) begin
    if (rst) begin
      m_prev  <= 1'b0;
      m_n     <= 0;
      e_len   <= 1'b0;
      e_sw    <= 1'b0;
      e_env   <= 1'b0;
      e_start <= 4'b0000;
    end else begin
      m_prev <= div[DB];
      if (!apu_en) begin
        m_n     <= 0;
        e_len   <= 1'b0;
        e_sw    <= 1'b0;
        e_env   <= 1'b0;
        e_start <= 4'b0000;
      end else begin
        e_start <= trig_wr;
        if (m_prev && !div[DB]) begin
          e_len <= ((m_n % 8) % 2) == 0;
          e_sw  <= ((m_n % 8) % 4) == 2;
          e_env <= (m_n % 8) == 7;
          m_n   <= m_n + 1;
        end else begin
          e_len <= 1'b0;
          e_sw  <= 1'b0;
          e_env <= 1'b0;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    chk("m_step",     8'(step),       8'(m_n % 8));
    chk("m_len_skip", 8'(len_skip),   8'(m_n % 2));
    chk("m_length",   8'(clk_length), 8'(e_len));
    chk("m_sweep",    8'(clk_sweep),  8'(e_sw));
    chk("m_env",      8'(clk_env),    8'(e_env));
    chk("m_start",    8'(start),      8'(e_start));
    n_len += int'(clk_length);
    n_sw  += int'(clk_sweep);
    n_env += int'(clk_env);
  endtask

  function automatic logic [DW-1:0] mk(input logic b);
    logic [DW-1:0] v;
    v     = DW'($urandom);
    v[DB] = b;
    return v;
  endfunction

  // Apply one cycle of inputs, then compare on the following falling edge.
  task automatic drive(input logic [DW-1:0] dv, input logic en, input logic [3:0] tw,
                       input logic r);
    div     = dv;
    apu_en  = en;
    trig_wr = tw;
    rst     = r;
    @(negedge clk);
    model_compare();
  endtask

  // High, high, fall: the strobe of this tick is visible when the task returns.
  task automatic tick(input logic en);
    drive(mk(1'b1), en, 4'b0000, 1'b0);
    drive(mk(1'b1), en, 4'b0000, 1'b0);
    drive(mk(1'b0), en, 4'b0000, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int l0, s0, e0;
    logic b;
    logic en;
    logic [3:0] tw;
    logic r;

    div = '0; apu_en = 1'b0; trig_wr = 4'b0000; rst = 1'b1;

    // Reset state
    drive(mk(1'b1), 1'b1, 4'b1111, 1'b1);
    drive(mk(1'b1), 1'b1, 4'b1111, 1'b1);
    chk("rst_step",   8'(step), 8'd0);
    chk("rst_strobe", 8'({clk_length, clk_sweep, clk_env}), 8'd0);
    chk("rst_start",  8'(start), 8'd0);
    chk("rst_skip",   8'(len_skip), 8'd0);

    // First cycle after release: bit low, no tick
    drive(mk(1'b0), 1'b1, 4'b0000, 1'b0);
    chk("rel_no_tick", 8'(clk_length), 8'd0);

    // Free run: 16 ticks
    l0 = n_len; s0 = n_sw; e0 = n_env;
    for (int t = 1; t <= 16; t++) begin
      tick(1'b1);
      if (t == 1) chk("t1_length", 8'(clk_length), 8'd1);
      if (t == 3) chk("t3_sweep",  8'(clk_sweep), 8'd1);
      if (t == 8) begin
        chk("t8_env",  8'(clk_env), 8'd1);
        chk("t8_step", 8'(step), 8'd0);
      end
      drive(mk(1'b0), 1'b1, 4'b0000, 1'b0);
      if (t == 1) chk("t1_width", 8'(clk_length), 8'd0);
    end
    chk("run_step",   8'(step), 8'd0);
    chk("run_length", 8'(n_len - l0), 8'd8);
    chk("run_sweep",  8'(n_sw - s0),  8'd4);
    chk("run_env",    8'(n_env - e0), 8'd2);

    // DIV write clearing bit 12 ticks once; a write with it already clear does not
    drive(16'h1000, 1'b1, 4'b0000, 1'b0);
    drive(16'h1000, 1'b1, 4'b0000, 1'b0);
    drive(16'h0000, 1'b1, 4'b0000, 1'b0);
    chk("divwr_tick", 8'(step), 8'd1);
    drive(16'h0000, 1'b1, 4'b0000, 1'b0);
    drive(16'h0000, 1'b1, 4'b0000, 1'b0);
    chk("divwr_none", 8'(step), 8'd1);

    // Drop apu_en at step 5, apply 3 ticks, re-enable
    for (int t = 0; t < 4; t++) tick(1'b1);
    chk("pre_dis_step", 8'(step), 8'd5);
    l0 = n_len + n_sw + n_env;
    drive(mk(1'b0), 1'b0, 4'b0000, 1'b0);
    for (int t = 0; t < 3; t++) tick(1'b0);
    chk("dis_step",    8'(step), 8'd0);
    chk("dis_strobes", 8'(n_len + n_sw + n_env - l0), 8'd0);
    tick(1'b1);
    chk("reen_length", 8'(clk_length), 8'd1);
    chk("reen_step",   8'(step), 8'd1);

    // Trigger coincident with a step-0 tick
    for (int t = 0; t < 7; t++) tick(1'b1);
    drive(mk(1'b1), 1'b1, 4'b0000, 1'b0);
    drive(mk(1'b1), 1'b1, 4'b0000, 1'b0);
    drive(mk(1'b0), 1'b1, 4'b1011, 1'b0);
    chk("coin_start",  8'(start), 8'h0b);
    chk("coin_length", 8'(clk_length), 8'd1);
    chk("coin_skip",   8'(len_skip), 8'd1);
    drive(mk(1'b0), 1'b1, 4'b0000, 1'b0);
    chk("coin_start_w",  8'(start), 8'h00);
    chk("coin_length_w", 8'(clk_length), 8'd0);
    chk("coin_skip_w",   8'(len_skip), 8'd1);

    // Trigger while disabled
    drive(mk(1'b0), 1'b0, 4'b0001, 1'b0);
    chk("dis_trig", 8'(start), 8'h00);
    drive(mk(1'b0), 1'b1, 4'b0000, 1'b0);

    // Reset at step 6 with a tick pending
    for (int t = 0; t < 6; t++) tick(1'b1);
    chk("pre_rst_step", 8'(step), 8'd6);
    drive(mk(1'b1), 1'b1, 4'b0000, 1'b0);
    drive(mk(1'b1), 1'b1, 4'b0000, 1'b0);
    drive(mk(1'b0), 1'b1, 4'b1111, 1'b1);
    chk("mid_rst_all", 8'({step, clk_length, clk_sweep, clk_env, len_skip}), 8'd0);
    chk("mid_rst_start", 8'(start), 8'd0);
    for (int t = 0; t < 3; t++) drive(mk(1'b0), 1'b1, 4'b0000, 1'b0);
    chk("post_rst_step", 8'(step), 8'd0);
    chk("post_rst_len",  8'(clk_length), 8'd0);

    // Randomized run
    b = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(2, 0) == 0) b = ~b;
      en = ($urandom_range(9, 0) != 0);
      tw = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'b0000;
      r  = ($urandom_range(99, 0) == 0);
      drive(mk(b), en, tw, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_frame_seq.md
# sound_frame_seq

Frame sequencer and trigger scheduler for the APU. Derives the 512 Hz frame-step timebase from the system divider and issues single-cycle clock strobes to the length counters, the channel 1 sweep unit and the volume envelopes. It also converts per-channel trigger writes into aligned one-cycle `start` pulses. It sits between the register file / timer block and the four sound channels, and is the only source of `clk_length_ctr`, sweep and envelope ticks.

## Interface
- `DIV_WIDTH`, default 16: width of the free-running system divider input.
- `DIV_BIT`, default 12: divider bit whose falling edge advances the sequencer (512 Hz at 4.194304 MHz).
- `clk` input, 1 bit: system clock; single clock domain.
- `rst` input, 1 bit: reset. Synchronous, active-high.
- `apu_en` input, 1 bit: master sound enable (NR52 bit 7).
- `div` input, `DIV_WIDTH` bits: system divider value. May jump to 0 on a DIV write.
- `trig_wr` input, 4 bits: one-cycle pulse per channel (bit i = channel i+1) on a register write with the trigger bit set.
- `step` output, 3 bits: index of the next frame step to execute.
- `clk_length` output, 1 bit: one-cycle length-counter tick.
- `clk_sweep` output, 1 bit: one-cycle sweep tick.
- `clk_env` output, 1 bit: one-cycle envelope tick.
- `start` output, 4 bits: one-cycle channel start pulses.
- `len_skip` output, 1 bit: high when the next step to execute does not clock length, i.e. `step[0]`==1.

## Operation
- Edge detect:
  - `div_q` registers `div[DIV_BIT]` every cycle, including while `apu_en`=0.
  - `tick` = `div_q` & ~`div[DIV_BIT]`.
  - A DIV write that clears a set bit produces a tick.
- Step execution on `tick` with `apu_en`=1, for current step s:
  - `clk_length` <= 1 when s ∈ {0,2,4,6}.
  - `clk_sweep` <= 1 when s ∈ {2,6}.
  - `clk_env` <= 1 when s = 7.
  - `step` <= s+1 mod 8. It wraps from 7 to 0 and has no terminal state.
- Strobes:
  - Registered and high for exactly one cycle.
  - Low on every cycle without a tick.
- Triggers:
  - `start[i]` <= `trig_wr[i]` & `apu_en`, registered, so each is a single cycle.
  - Multiple channels may start in the same cycle.
- `apu_en`=0:
  - `step` forced to 0.
  - All strobes and `start` forced to 0.
  - Ticks are discarded.
  - When `apu_en` returns to 1, sequencing resumes from step 0 on the next tick.
- Simultaneous events:
  - A tick and a trigger in the same cycle assert `clk_length` and `start[i]` in the same output cycle.
  - Downstream length counters give `start` priority; this block does not suppress either signal.
  - `len_skip` lets channels apply the extra-length-clock rule on trigger.
- Reset:
  - `rst` overrides everything, including mid-sequence.
  - Reset values: `step`=0, `div_q`=0, `clk_length`/`clk_sweep`/`clk_env`=0, `start`=0, `len_skip`=0.
  - No tick is generated in the first cycle after reset release, because `div_q`=0.

## Timing
- Tick latency: `div[DIV_BIT]` sampled 1 in cycle N−1 and 0 in cycle N → strobe high in cycle N+1. `step` updates at the same edge.
- Trigger latency: `trig_wr[i]` high in cycle N → `start[i]` high in cycle N+1 only.
- `len_skip` is combinational from the `step` register, so it is valid in the same cycle as `step`.
- Full frame: 8 ticks give 4 length, 2 sweep and 1 envelope strobe. Nominal rates are 256/128/64 Hz.
- The `apu_en` fall takes effect at the next clock edge. A tick in that same cycle is dropped.

## Test plan
- Free run, `apu_en`=1, 16 ticks from reset:
  - `clk_length` on ticks 1,3,5,7,9,11,13,15.
  - `clk_sweep` on ticks 3,7,11,15.
  - `clk_env` on ticks 8,16.
  - `step` returns to 0 after tick 8 and tick 16.
  - Each strobe is 1 cycle wide, 1 cycle after the div bit falls.
- DIV write with bit 12 set (div 0x1000→0x0000) → one tick. A write with bit 12 clear → no tick.
- `apu_en` dropped at `step`=5, 3 ticks applied, then re-enabled → `step` reads 0 while disabled, no strobes. The first tick after enable produces `clk_length` (step 0).
- `trig_wr`=4'b1011 coincident with a step-0 tick → `start`=4'b1011 and `clk_length`=1 in the same cycle, both for 1 cycle. `len_skip`=1 afterwards.
- `trig_wr`=4'b0001 with `apu_en`=0 → `start` remains 0.
- `rst` asserted at `step`=6 while a strobe is pending → all outputs 0 on the next cycle. Holding div bit 12 at 0 after release produces no tick.
